// File: rtl/fp_serializer_pkg.sv
`default_nettype none
// ============================================================================
// fp_pkg : shared types for the FP pixel vector serializer/deserializer pair
// Rev 1.0
// ============================================================================
package fp_pkg;

    localparam int DATA_W = 32;

    typedef logic [DATA_W-1:0] fp_word_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } ser_state_e;

endpackage
`default_nettype wire

// File: rtl/fp_serializer.sv
`default_nettype none
// ============================================================================
// fp_serializer : snapshots a NUM_WORDS x DATA_W vector, streams word 0 first
// Rev 1.0
// ============================================================================
module fp_serializer #(
    parameter  int NUM_WORDS = 32,
    parameter  int DATA_W    = 32,
    localparam int IDX_W     = $clog2(NUM_WORDS)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              clear,
    input  logic [NUM_WORDS-1:0][DATA_W-1:0]  data_in,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_W-1:0]                 out_data,
    output logic [IDX_W-1:0]                  out_index,
    output logic                              out_last,
    output logic                              busy,
    output logic                              done
);
    import fp_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    ser_state_e                      state_q, state_d;
    logic [IDX_W-1:0]                cnt_q, cnt_d;
    logic                            done_q, done_d;
    logic [NUM_WORDS-1:0][DATA_W-1:0] buf_q;
    logic                            capture;
    logic                            at_last;

    assign at_last = (cnt_q == LAST_IDX);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        capture = 1'b0;
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = STREAM;
                        cnt_d   = '0;
                        capture = 1'b1;
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        if (at_last) begin
                            state_d = IDLE;
                            cnt_d   = '0;
                            done_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            if (clear) begin
                buf_q <= '0;
            end else if (capture) begin
                buf_q <= data_in;
            end
        end
    end

    // Word is read through a mux on the counter; outputs are zero outside STREAM.
    assign out_valid = (state_q == STREAM);
    assign busy      = (state_q == STREAM);
    assign out_data  = out_valid ? buf_q[cnt_q] : '0;
    assign out_index = out_valid ? cnt_q : '0;
    assign out_last  = out_valid && at_last;
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_serializer.sv
`default_nettype none
// ============================================================================
// tb_fp_serializer : directed checks of the FP vector serializer
// Rev 1.0
// ============================================================================
module tb_fp_serializer;

    localparam int NW = 32;
    localparam int DW = 32;
    localparam int IW = $clog2(NW);

    typedef logic [NW-1:0][DW-1:0] vec_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          clear;
    vec_t          data_in;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_index;
    logic          out_last;
    logic          busy;
    logic          done;

    int   n_vec;
    int   n_err;
    vec_t vec_a;
    vec_t vec_b;
    vec_t rx;

    fp_serializer #(.NUM_WORDS(NW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .clear     (clear),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input vec_t v);
        data_in = v;
        start   = 1'b1;
        step();
        start   = 1'b0;
        chk("first_valid", 32'(out_valid), 32'd1);
        chk("first_busy",  32'(busy),      32'd1);
        chk("first_idx",   32'(out_index), 32'd0);
    endtask

    // Expects word from_idx on the bus; runs until word to_idx is accepted.
    task automatic run(input vec_t exp, input int from_idx, input int to_idx,
                       input int ready_pct, input bit scramble);
        int idx = from_idx;
        int budget = 2000;
        while (idx <= to_idx && budget > 0) begin
            budget--;
            chk("valid", 32'(out_valid), 32'd1);
            chk("data",  out_data, exp[idx]);
            chk("index", 32'(out_index), 32'(idx));
            chk("last",  32'(out_last), 32'(idx == NW - 1));
            chk("done_mid", 32'(done), 32'd0);
            out_ready = ($urandom_range(99) < ready_pct);
            if (scramble) data_in = {NW{32'hDEAD_BEEF}};
            if (out_ready) rx[idx] = out_data;
            step();
            if (out_ready) idx++;
        end
        out_ready = 1'b0;
        if (budget == 0) chk("run_timeout", 32'd0, 32'd1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_busy"},  32'(busy),      32'd0);
        chk({tag, "_data"},  out_data,       32'd0);
        chk({tag, "_index"}, 32'(out_index), 32'd0);
        chk({tag, "_last"},  32'(out_last),  32'd0);
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b0;
        data_in   = '0;
        rx        = '0;
        for (int i = 0; i < NW; i++) begin
            vec_a[i] = 32'h3F80_0000 + 32'(i);
            vec_b[i] = 32'h4049_0F00 ^ (32'(i) * 32'h0101_0011);
        end

        #1;
        chk_idle("reset");
        chk("reset_done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        chk_idle("post_reset");

        // Basic stream, full rate
        launch(vec_a);
        run(vec_a, 0, NW - 1, 100, 1'b0);
        chk("basic_done", 32'(done), 32'd1);
        chk_idle("basic_end");

        // Start in the done cycle, backpressure, data_in scrambled after capture
        data_in = vec_b;
        start   = 1'b1;
        step();
        start   = 1'b0;
        chk("restart_valid", 32'(out_valid), 32'd1);
        chk("restart_idx",   32'(out_index), 32'd0);
        run(vec_b, 0, NW - 1, 50, 1'b1);
        chk("bp_done", 32'(done), 32'd1);
        step();
        chk("done_pulse_len", 32'(done), 32'd0);

        // Abort after beat 10
        launch(vec_a);
        run(vec_a, 0, 10, 100, 1'b0);
        chk("abort_idx_before", 32'(out_index), 32'd11);
        clear     = 1'b1;
        out_ready = 1'b1;
        step();
        clear     = 1'b0;
        out_ready = 1'b0;
        chk_idle("abort");
        chk("abort_done", 32'(done), 32'd0);
        step();
        chk("abort_done2", 32'(done), 32'd0);

        // New vector after abort; start at index 5 is ignored
        launch(vec_b);
        run(vec_b, 0, 4, 100, 1'b0);
        chk("ign_idx5", 32'(out_index), 32'd5);
        data_in   = vec_a;
        start     = 1'b1;
        out_ready = 1'b1;
        step();
        start     = 1'b0;
        out_ready = 1'b0;
        run(vec_b, 6, NW - 1, 100, 1'b0);
        chk("ign_done", 32'(done), 32'd1);
        step();

        // start + clear in IDLE: clear wins
        data_in = vec_a;
        start   = 1'b1;
        clear   = 1'b1;
        step();
        start   = 1'b0;
        clear   = 1'b0;
        chk_idle("startclr");
        step();
        chk("startclr_valid2", 32'(out_valid), 32'd0);

        // Clear on the final beat suppresses done
        launch(vec_a);
        run(vec_a, 0, NW - 2, 100, 1'b0);
        chk("clrlast_last", 32'(out_last), 32'd1);
        out_ready = 1'b1;
        clear     = 1'b1;
        step();
        out_ready = 1'b0;
        clear     = 1'b0;
        chk("clrlast_done", 32'(done), 32'd0);
        chk_idle("clrlast");

        // Async reset at index 17
        launch(vec_b);
        run(vec_b, 0, 16, 100, 1'b0);
        chk("arst_idx17", 32'(out_index), 32'd17);
        #1 rst_n = 1'b0;
        #1;
        chk_idle("arst");
        chk("arst_done", 32'(done), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        chk_idle("arst_release");

        // Round trip: collected words rebuild the vector
        rx = '0;
        launch(vec_a);
        run(vec_a, 0, NW - 1, 70, 1'b0);
        chk("rt_done", 32'(done), 32'd1);
        for (int i = 0; i < NW; i++) chk("roundtrip", rx[i], vec_a[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
